// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: N iterations per product, with a registered 2N-bit result.
// Optional macro MUL_EARLY_TERM_EN: BUSY also stops as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req,
  input  logic [N-1:0] Multiplicand,
  input  logic [N-1:0] Multiplier,
  output logic [N-1:0] P,
  output logic [N-1:0] Phi,
  output logic         ready,
  output logic         exception
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         state_next;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_sum;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           zero_op;
  logic           last_iter;

  always_comb begin
    acc_sum = mplier[0] ? (acc + mcand) : acc;
    zero_op = (Multiplicand == '0) || (Multiplier == '0);
`ifdef MUL_EARLY_TERM_EN
    last_iter = (cnt == LAST) || ((mplier >> 1) == '0);
`else
    last_iter = (cnt == LAST);
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = zero_op ? DONE : BUSY;
      BUSY: if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // The result is captured from the final iteration's sum, so DONE shows it immediately.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      P         <= '0;
      Phi       <= '0;
      ready     <= 1'b0;
      exception <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            mcand  <= {{N{1'b0}}, Multiplicand};
            mplier <= Multiplier;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) begin
              P         <= '0;
              Phi       <= '0;
              exception <= 1'b0;
              ready     <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            P         <= acc_sum[N-1:0];
            Phi       <= acc_sum[2*N-1:N];
            exception <= |acc_sum[2*N-1:N];
            ready     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (N=16); latency expectations follow MUL_EARLY_TERM_EN.
module tb_seq_multiplier;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req;
  logic [N-1:0] Multiplicand;
  logic [N-1:0] Multiplier;
  logic [N-1:0] P;
  logic [N-1:0] Phi;
  logic         ready;
  logic         exception;

  int checks = 0;
  int errors = 0;
  logic [2*N:0] exp_q[$];

  seq_multiplier #(.N(N)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .P(P), .Phi(Phi), .ready(ready), .exception(exception)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges from the accepting edge (counted as 1) to the edge that raises ready.
  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    int hb;
    if (a == '0 || b == '0) return 1;
`ifdef MUL_EARLY_TERM_EN
    hb = 0;
    for (int i = 0; i < N; i++) if (b[i]) hb = i;
    return hb + 2;
`else
    return N + 1;
`endif
  endfunction

  // Edges until ready, counting the first edge as 1; returns 0 on timeout.
  task automatic wait_ready(input int budget, output int edges);
    edges = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (ready) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic score(input string tag);
    logic [2*N:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, "_p"}, 32'(P), 32'(e[N-1:0]));
    check_val({tag, "_phi"}, 32'(Phi), 32'(e[2*N-1:N]));
    check_val({tag, "_exc"}, 32'(exception), 32'(e[2*N]));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ep, input logic [N-1:0] ephi, input logic eexc);
    int edges;
    @(negedge clk);
    Multiplicand = a;
    Multiplier   = b;
    req          = 1'b1;
    exp_q.push_back({eexc, ephi, ep});
    wait_ready(40, edges);
    check_val({tag, "_lat"}, 32'(edges), 32'(exp_lat(a, b)));
    score(tag);
    @(posedge clk); #1;
    check_val({tag, "_ready_1cyc"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int edges;
    int strobes;
    rstn = 1'b0;
    req = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_p", 32'(P), 32'd0);
    check_val("rst_phi", 32'(Phi), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_exc", 32'(exception), 32'd0);
    @(negedge clk) rstn = 1'b1;

    run_op("m3x5", 16'd3, 16'd5, 16'd15, 16'd0, 1'b0);
    run_op("mffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1);
    run_op("zero_a", 16'h0000, 16'h1234, 16'd0, 16'd0, 1'b0);
    run_op("zero_b", 16'h0005, 16'h0000, 16'd0, 16'd0, 1'b0);
    run_op("ovf", 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b1);
    run_op("m1234", 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1);

    // Requests and operand changes during BUSY must be ignored.
    @(negedge clk);
    Multiplicand = 16'd7;
    Multiplier = 16'd9;
    req = 1'b1;
    exp_q.push_back({1'b0, 16'd0, 16'd63});
    @(posedge clk); #1;
    Multiplicand = 16'd2;
    Multiplier = 16'd2;
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    wait_ready(40, edges);
    check_val("busy_req_lat", 32'(edges), 32'(exp_lat(16'd7, 16'd9) - 3));
    score("busy_req");
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) strobes++;
    end
    check_val("busy_req_no_second", 32'(strobes), 32'd0);

    // Reset mid-BUSY aborts with no strobe.
    @(negedge clk);
    Multiplicand = 16'h00FF;
    Multiplier = 16'h0100;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk); #1;
    check_val("abort_p", 32'(P), 32'd0);
    check_val("abort_phi", 32'(Phi), 32'd0);
    check_val("abort_ready", 32'(ready), 32'd0);
    check_val("abort_exc", 32'(exception), 32'd0);
    @(negedge clk) rstn = 1'b1;
    strobes = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ready) strobes++;
    end
    check_val("abort_no_ready", 32'(strobes), 32'd0);
    run_op("m4x4", 16'd4, 16'd4, 16'd16, 16'd0, 1'b0);

    // req held high: back-to-back operations separated by one IDLE cycle.
    @(negedge clk);
    Multiplicand = 16'd2;
    Multiplier = 16'd3;
    req = 1'b1;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        edges = i;
        break;
      end
    end
    check_val("b2b_first_lat", 32'(edges), 32'(exp_lat(16'd2, 16'd3)));
    check_val("b2b_first_p", 32'(P), 32'd6);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 2) req = 1'b0;
      if (ready) begin
        edges = i;
        break;
      end
    end
    check_val("b2b_gap", 32'(edges), 32'(exp_lat(16'd2, 16'd3) + 1));
    check_val("b2b_second_p", 32'(P), 32'd6);
    check_val("b2b_second_phi", 32'(Phi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
